// File: rtl/clint_itrp_gen.sv
// clint_itrp_gen: CLINT registers (msip/mtimecmp/mtime) plus one-hot machine interrupt arbiter
module clint_itrp_gen #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clint_req,
  input  logic        clint_wen,
  input  logic [63:0] clint_addr,
  input  logic [63:0] clint_wdata,
  input  logic [7:0]  clint_wmask,
  output logic        clint_sel,
  output logic        clint_ack,
  output logic [63:0] clint_rdata,
  input  logic        ext_irq,
  input  logic [63:0] mstatus_rd_data,
  input  logic [63:0] mie_rd_data,
  input  logic        commit_valid,
  output logic [2:0]  itrp_info,
  output logic [63:0] mtime_o
);
  localparam logic [63:0] LAST_ADDR = BASE_ADDR + 64'hFFFF;
  localparam logic [15:0] DIV_M1    = 16'(TICK_DIV - 1);
  logic        msip_q, msip_d;
  logic [63:0] cmp_q, cmp_d;
  logic [63:0] mtime_q, mtime_d;
  logic [15:0] pre_q, pre_d;
  logic        ext_q, ext_d;
  logic        ack_q, ack_d;
  logic [63:0] rdata_q, rdata_d;
  logic        acc, wr, hit_msip, hit_cmp, hit_mtime, tick, go;
  logic        soft_req, timer_req, ext_req;
  logic [15:0] off;
  logic [63:0] wbits, cur;
  logic        unused_bits;
  assign unused_bits = ^{mstatus_rd_data, mie_rd_data, off[2:0]};
  always_comb begin
    clint_sel = (clint_addr >= BASE_ADDR) && (clint_addr <= LAST_ADDR);
    acc       = clint_req && clint_sel;
    wr        = acc && clint_wen;
    off       = clint_addr[15:0] - BASE_ADDR[15:0];
    hit_msip  = off[15:3] == 13'h0000;
    hit_cmp   = off[15:3] == 13'h0800;
    hit_mtime = off[15:3] == 13'h17FF;
    wbits     = '0;
    for (int i = 0; i < 8; i++) wbits[8*i +: 8] = {8{clint_wmask[i]}};
    cur       = hit_msip ? {63'b0, msip_q} : hit_cmp ? cmp_q : hit_mtime ? mtime_q : '0;
    tick      = pre_q == DIV_M1;
    msip_d    = (wr && hit_msip && clint_wmask[0]) ? clint_wdata[0] : msip_q;
    cmp_d     = (wr && hit_cmp) ? (clint_wdata & wbits) | (cmp_q & ~wbits) : cmp_q;
    // a bus write to mtime overrides the tick and restarts the prescaler
    mtime_d   = (wr && hit_mtime) ? (clint_wdata & wbits) | (mtime_q & ~wbits) :
                tick ? mtime_q + 64'd1 : mtime_q;
    pre_d     = ((wr && hit_mtime) || tick) ? '0 : pre_q + 16'd1;
    ext_d     = ext_irq;
    ack_d     = acc;
    rdata_d   = (acc && !clint_wen) ? cur : '0;
  end
  always_comb begin
    go        = commit_valid && mstatus_rd_data[3];
    soft_req  = go && msip_q && mie_rd_data[3];
    timer_req = go && (mtime_q >= cmp_q) && mie_rd_data[7];
    ext_req   = go && ext_q && mie_rd_data[11];
    itrp_info = ext_req ? 3'b100 : soft_req ? 3'b001 : timer_req ? 3'b010 : 3'b000;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      msip_q  <= 1'b0;
      cmp_q   <= '1;
      mtime_q <= '0;
      pre_q   <= '0;
      ext_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      msip_q  <= msip_d;
      cmp_q   <= cmp_d;
      mtime_q <= mtime_d;
      pre_q   <= pre_d;
      ext_q   <= ext_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end
  assign clint_ack   = ack_q;
  assign clint_rdata = rdata_q;
  assign mtime_o     = mtime_q;
endmodule
